// File: rtl/fpga_exit_reporter_pkg.sv
// Shared types and constants for the exit-status reporter.
//   tx_state_t : serializer states (IDLE/START/DATA/STOP)
//   MSG_LEN    : characters per report line "EXIT=XXXXXXXX\r\n"
//   hex_ascii  : nibble -> uppercase ASCII hex digit
//   msg_char   : character at a given line position for a captured value
package fpga_exit_reporter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int         MSG_LEN   = 15;
  localparam logic [3:0] LAST_CHAR = 4'(MSG_LEN - 1);

  localparam logic [7:0] ASCII_E  = 8'h45;
  localparam logic [7:0] ASCII_X  = 8'h58;
  localparam logic [7:0] ASCII_I  = 8'h49;
  localparam logic [7:0] ASCII_T  = 8'h54;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] w_char;
    if (nib < 4'd10) w_char = 8'h30 + {4'h0, nib};
    else             w_char = 8'h41 + ({4'h0, nib} - 8'd10);
    return w_char;
  endfunction

  // Positions 5..12 carry the value most-significant nibble first.
  function automatic logic [7:0] msg_char(input logic [3:0] idx, input logic [31:0] value);
    logic [7:0] w_char;
    w_char = ASCII_LF;
    case (idx)
      4'd0:  w_char = ASCII_E;
      4'd1:  w_char = ASCII_X;
      4'd2:  w_char = ASCII_I;
      4'd3:  w_char = ASCII_T;
      4'd4:  w_char = ASCII_EQ;
      4'd5:  w_char = hex_ascii(value[31:28]);
      4'd6:  w_char = hex_ascii(value[27:24]);
      4'd7:  w_char = hex_ascii(value[23:20]);
      4'd8:  w_char = hex_ascii(value[19:16]);
      4'd9:  w_char = hex_ascii(value[15:12]);
      4'd10: w_char = hex_ascii(value[11:8]);
      4'd11: w_char = hex_ascii(value[7:4]);
      4'd12: w_char = hex_ascii(value[3:0]);
      4'd13: w_char = ASCII_CR;
      default: w_char = ASCII_LF;
    endcase
    return w_char;
  endfunction

endpackage

// File: rtl/fpga_exit_status_reporter_tx.sv
// 8N1 UART byte serializer, LSB first, idle high.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_valid/i_data : byte offered for transmission
//   o_ready        : high on the edge where an offered byte is accepted
//                    (idle, or last cycle of a stop bit -> back-to-back frames)
//   o_tx           : serial output (registered)
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | line high, waiting for a byte
// START | driving the start bit (0)
// DATA  | driving data bits 0..7, LSB first
// STOP  | driving the stop bit (1); may chain into START
module fpga_uart_tx_byte
  import fpga_exit_reporter_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_tx
);

  localparam int                CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        r_state,    w_state_nxt;
  logic [CNT_W-1:0] r_baud_cnt, w_baud_cnt_nxt;
  logic [2:0]       r_bit_idx,  w_bit_idx_nxt;
  logic [7:0]       r_shift,    w_shift_nxt;
  logic             r_tx,       w_tx_nxt;
  logic             w_bit_end;

  assign w_bit_end = (r_baud_cnt == CNT_LAST);
  assign o_tx      = r_tx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_baud_cnt_nxt = w_bit_end ? '0 : r_baud_cnt + 1'b1;
    w_bit_idx_nxt  = r_bit_idx;
    w_shift_nxt    = r_shift;
    w_tx_nxt       = r_tx;
    o_ready        = 1'b0;
    case (r_state)
      IDLE: begin
        o_ready        = 1'b1;
        w_baud_cnt_nxt = '0;
        w_tx_nxt       = 1'b1;
        if (i_valid) begin
          w_state_nxt = START;
          w_shift_nxt = i_data;
          w_tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt   = DATA;
          w_bit_idx_nxt = 3'd0;
          w_tx_nxt      = r_shift[0];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_shift_nxt   = {1'b0, r_shift[7:1]};
            w_tx_nxt      = r_shift[1];
          end
        end
      end
      STOP: begin
        // Accepting here makes the next start bit follow the stop bit with no gap.
        o_ready = w_bit_end;
        if (w_bit_end) begin
          if (i_valid) begin
            w_state_nxt = START;
            w_shift_nxt = i_data;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = IDLE;
            w_tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fpga_exit_status_reporter.sv
// Reports the program exit value over a debug UART and on pass/fail LEDs.
// A rising edge of exit_valid_i while idle captures exit_value_i and sends
// "EXIT=XXXXXXXX\r\n" (uppercase hex, MSB nibble first) as 8N1 frames.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   exit_valid_i   : exit valid level (synchronous to clk_i)
//   exit_value_i   : 32-bit exit value
//   uart_tx_o      : debug UART TX, idle high
//   busy_o         : message in progress
//   done_o         : sticky, at least one message completed
//   led_pass_o     : last completed message reported zero
//   led_fail_o     : last completed message reported non-zero
module fpga_exit_status_reporter
  import fpga_exit_reporter_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 15_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        uart_tx_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        led_pass_o,
  output logic        led_fail_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

  if (CLKS_PER_BIT < 2) begin : g_baud_check
    $error("fpga_exit_status_reporter: CLKS_PER_BIT must be at least 2");
  end

  logic        r_valid_q;
  logic [31:0] r_value;
  logic [3:0]  r_char_idx;
  logic        r_busy;
  logic        r_done;
  logic        r_led_pass;
  logic        r_led_fail;

  logic        w_rise;
  logic        w_start;
  logic        w_byte_valid;
  logic [7:0]  w_byte_data;
  logic        w_byte_ready;
  logic        w_tx;
  logic [3:0]  w_next_idx;

  assign w_rise     = exit_valid_i & ~r_valid_q;
  assign w_start    = w_rise & ~r_busy;
  assign w_next_idx = r_char_idx + 4'd1;

  // The first character goes straight to the serializer on the capture edge so
  // the start bit begins on that same edge; later characters are offered for
  // the whole message and taken at each stop-bit end.
  assign w_byte_valid = w_start | (r_busy & (r_char_idx != LAST_CHAR));
  assign w_byte_data  = w_start ? ASCII_E : msg_char(w_next_idx, r_value);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_q  <= 1'b0;
      r_value    <= '0;
      r_char_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_led_pass <= 1'b0;
      r_led_fail <= 1'b0;
    end else begin
      r_valid_q <= exit_valid_i;
      if (w_start) begin
        r_value    <= exit_value_i;
        r_char_idx <= '0;
        r_busy     <= 1'b1;
      end else if (r_busy && w_byte_ready) begin
        // While busy, ready only pulses at the end of a stop bit.
        if (r_char_idx == LAST_CHAR) begin
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_led_pass <= (r_value == '0);
          r_led_fail <= (r_value != '0);
        end else begin
          r_char_idx <= w_next_idx;
        end
      end
    end
  end

  fpga_uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_valid (w_byte_valid),
    .i_data  (w_byte_data),
    .o_ready (w_byte_ready),
    .o_tx    (w_tx)
  );

  assign uart_tx_o  = w_tx;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign led_pass_o = r_led_pass;
  assign led_fail_o = r_led_fail;

endmodule

// File: tb/tb_fpga_exit_status_reporter.sv
module tb_fpga_exit_status_reporter;

  localparam int CPB        = 10;
  localparam int MSG_CYCLES = 15 * 10 * CPB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exit_valid = 1'b0;
  logic [31:0] exit_value = '0;
  logic        uart_tx, busy, done, led_pass, led_fail;

  always #5 clk = ~clk;

  fpga_exit_status_reporter #(
    .CLK_FREQ_HZ (1_000_000),
    .BAUD_RATE   (100_000)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .exit_valid_i (exit_valid),
    .exit_value_i (exit_value),
    .uart_tx_o    (uart_tx),
    .busy_o       (busy),
    .done_o       (done),
    .led_pass_o   (led_pass),
    .led_fail_o   (led_fail)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got \"%s\" expected \"%s\" at %0t", name, act, exp, $time);
    end
  endtask

  // Reference line text from the character rules.
  function automatic string msg_str(input logic [31:0] v);
    string s;
    s = "EXIT=";
    for (int i = 7; i >= 0; i--) begin
      int n;
      n = int'((v >> (4 * i)) & 32'hF);
      s = {s, $sformatf("%c", byte'((n < 10) ? (48 + n) : (65 + n - 10)))};
    end
    s = {s, "\r\n"};
    return s;
  endfunction

  // Behavioural model: a message is a 1500-cycle bit waveform started at capture.
  logic        m_prev = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_pass = 1'b0, m_fail = 1'b0;
  int          m_k = 0;
  logic [31:0] m_val = '0;
  logic        m_bits [150];

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_prev = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0; m_fail = 1'b0; m_k = 0;
    end else begin
      if (m_busy) begin
        m_k++;
        if (m_k == MSG_CYCLES) begin
          m_busy = 1'b0; m_done = 1'b1;
          m_pass = (m_val == 0); m_fail = (m_val != 0);
        end
      end else if (exit_valid && !m_prev) begin
        string s;
        m_val = exit_value;
        s = msg_str(m_val);
        for (int c = 0; c < 15; c++) begin
          byte ch;
          ch = s[c];
          m_bits[c*10] = 1'b0;
          for (int b = 0; b < 8; b++) m_bits[c*10 + 1 + b] = ch[b];
          m_bits[c*10 + 9] = 1'b1;
        end
        m_busy = 1'b1;
        m_k = 0;
      end
      m_prev = exit_valid;
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("tx",       uart_tx,  m_busy ? m_bits[m_k / CPB] : 1'b1);
    chk("busy",     busy,     m_busy);
    chk("done",     done,     m_done);
    chk("led_pass", led_pass, m_pass);
    chk("led_fail", led_fail, m_fail);
  end

  // Independent UART receiver sampling mid-bit.
  byte  rx_q [$];
  logic rx_act = 1'b0;
  int   rx_cnt = 0;
  logic [7:0] rx_sh = '0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      rx_act = 1'b0;
    end else if (rx_act) begin
      rx_cnt++;
      if (rx_cnt % 10 == 5) begin
        int b;
        b = rx_cnt / 10;
        if (b >= 1 && b <= 8) rx_sh[b-1] = uart_tx;
        else if (b == 9) begin
          chk("rx_stop_bit", uart_tx, 1'b1);
          rx_q.push_back(rx_sh);
          rx_act = 1'b0;
        end
      end
    end else if (uart_tx === 1'b0) begin
      rx_act = 1'b1;
      rx_cnt = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0: plain; 1: value change + valid toggle mid-frame; 2: rise on completion edge
  task automatic send(input logic [31:0] v, input int mode, input string exp_s);
    int    bc;
    string s;
    exit_valid = 1'b0;
    tick(1);
    rx_q.delete();
    exit_value = v;
    exit_valid = 1'b1;
    tick(1);
    chk("tx_low_at_capture", uart_tx, 1'b0);
    chk("busy_at_capture", busy, 1'b1);
    bc = 0;
    while (busy === 1'b1 && bc < MSG_CYCLES + 50) begin
      tick(1);
      bc++;
      if (mode == 1) begin
        if (bc == 300) exit_value = $urandom;
        if (bc == 400) exit_valid = 1'b0;
        if (bc == 410) exit_valid = 1'b1;
      end else if (mode == 2) begin
        if (bc == MSG_CYCLES - 2) exit_valid = 1'b0;
        if (bc == MSG_CYCLES - 1) exit_valid = 1'b1;
      end
    end
    chk("busy_cycles", bc, MSG_CYCLES);
    tick(3);
    if (mode == 2) chk("coincident_rise_ignored", busy, 1'b0);
    chk("rx_byte_count", rx_q.size(), 15);
    s = "";
    foreach (rx_q[i]) s = {s, $sformatf("%c", rx_q[i])};
    chk_str("rx_line", s, exp_s);
  endtask

  task automatic reset_mid(input logic [31:0] v, input int at);
    exit_valid = 1'b0;
    tick(1);
    exit_value = v;
    exit_valid = 1'b1;
    tick(1);
    tick(at);
    exit_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_tx_high", uart_tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_led_pass", led_pass, 1'b0);
    chk("rst_led_fail", led_fail, 1'b0);
    tick(3);
    rst_n = 1'b1;
    rx_q.delete();
    tick(200);
    chk("no_bytes_after_reset", rx_q.size(), 0);
    chk("idle_after_reset", busy, 1'b0);
  endtask

  initial begin
    chk_str("model_pin_2a", msg_str(32'h0000_002A), "EXIT=0000002A\r\n");
    chk_str("model_pin_beef", msg_str(32'hDEAD_BEEF), "EXIT=DEADBEEF\r\n");

    rst_n = 1'b0;
    tick(3);
    chk("reset_tx", uart_tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_leds", {led_pass, led_fail}, 2'b00);
    rst_n = 1'b1;
    tick(2);

    send(32'h0000_002A, 0, "EXIT=0000002A\r\n");
    chk("t1_done", done, 1'b1);
    chk("t1_leds", {led_pass, led_fail}, 2'b01);

    send(32'h0000_0000, 0, "EXIT=00000000\r\n");
    chk("t2_leds", {led_pass, led_fail}, 2'b10);

    send(32'hDEAD_BEEF, 1, "EXIT=DEADBEEF\r\n");
    chk("t3_leds", {led_pass, led_fail}, 2'b01);

    send(32'h0000_0000, 2, "EXIT=00000000\r\n");
    send(32'h0000_0001, 1, "EXIT=00000001\r\n");
    chk("t4_leds", {led_pass, led_fail}, 2'b01);

    reset_mid(32'h1234_5678, 750);
    send(32'hCAFE_0001, 0, "EXIT=CAFE0001\r\n");

    for (int it = 0; it < 14; it++) begin
      logic [31:0] v;
      v = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      repeat ($urandom_range(0, 20)) begin
        exit_value = $urandom;
        tick(1);
      end
      if ($urandom_range(0, 5) == 0) reset_mid(v, $urandom_range(1, MSG_CYCLES - 1));
      else send(v, $urandom_range(0, 2), msg_str(v));
    end

    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
